// File: rtl/block_unpacker.sv
// Splits one packed word of up to 2*MAX_NUM_BLOCKS blocks into output beats
// of at most MAX_NUM_BLOCKS blocks each, under valid/ready backpressure.
module block_unpacker #(
  parameter int unsigned BLOCK_SIZE     = 64,
  parameter int unsigned MAX_NUM_BLOCKS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  in_ready,
  input  logic [2*MAX_NUM_BLOCKS*BLOCK_SIZE-1:0] in_data,
  input  logic                                  in_valid,
  input  logic [31:0]                           in_num,
  input  logic                                  in_last,
  input  logic                                  ready_4_output,
  output logic [MAX_NUM_BLOCKS*BLOCK_SIZE-1:0]  out_data,
  output logic                                  out_valid,
  output logic [31:0]                           out_num,
  output logic                                  out_last
);

  localparam int unsigned IN_BLOCKS = 2 * MAX_NUM_BLOCKS;
  localparam int unsigned REM_W     = $clog2(IN_BLOCKS + 1);
  localparam int unsigned IDX_W     = $clog2(IN_BLOCKS);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [BLOCK_SIZE-1:0]  buf_q [IN_BLOCKS];
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [REM_W-1:0]       ptr_q, ptr_d;
  logic                   last_q, last_d;
  logic                   load;
  logic [REM_W-1:0]       n_eff;
  logic [REM_W-1:0]       num_c;

  // Oversized counts are clamped to the word capacity
  always_comb begin
    if (in_num > 32'(IN_BLOCKS)) n_eff = REM_W'(IN_BLOCKS);
    else                         n_eff = REM_W'(in_num);
  end

  always_comb begin
    if (state_q != DRAIN)                   num_c = '0;
    else if (rem_q > REM_W'(MAX_NUM_BLOCKS)) num_c = REM_W'(MAX_NUM_BLOCKS);
    else                                     num_c = rem_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // Empty non-last words are swallowed without producing a beat
        if (in_valid && ((n_eff != '0) || in_last)) begin
          load    = 1'b1;
          rem_d   = n_eff;
          ptr_d   = '0;
          last_d  = in_last;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ready_4_output) begin
          rem_d = rem_q - num_c;
          ptr_d = ptr_q + num_c;
          if (rem_q == num_c) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < int'(IN_BLOCKS); i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      if (load) begin
        for (int i = 0; i < int'(IN_BLOCKS); i++)
          buf_q[i] <= in_data[i*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  // Output decode from registers only; lanes above out_num stay zero
  always_comb begin
    out_data = '0;
    for (int k = 0; k < int'(MAX_NUM_BLOCKS); k++) begin
      if (REM_W'(k) < num_c)
        out_data[k*BLOCK_SIZE +: BLOCK_SIZE] = buf_q[IDX_W'(ptr_q + REM_W'(k))];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_num   = 32'(num_c);
  assign out_last  = (state_q == DRAIN) && last_q && (rem_q <= REM_W'(MAX_NUM_BLOCKS));

endmodule

// File: tb/tb_block_unpacker.sv
// Directed bench for block_unpacker with MAX_NUM_BLOCKS=2, BLOCK_SIZE=8.
module tb_block_unpacker;

  logic        clk;
  logic        rst;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] in_num;
  logic        in_last;
  logic        ready_4_output;
  logic [15:0] out_data;
  logic        out_valid;
  logic [31:0] out_num;
  logic        out_last;

  int total;
  int bad;
  int blk_sum;

  block_unpacker #(.BLOCK_SIZE(8), .MAX_NUM_BLOCKS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_num         (in_num),
    .in_last        (in_last),
    .ready_4_output (ready_4_output),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_num        (out_num),
    .out_last       (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [15:0] d, input int n, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_num"},   out_num,        32'(n));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  task automatic send(input logic [31:0] d, input int n, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_num   = 32'(n);
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
  endtask

  initial begin
    total = 0;
    bad = 0;
    blk_sum = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_num = '0;
    in_last = 1'b0;
    ready_4_output = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_num",   out_num,        32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Three-block last word
    ready_4_output = 1'b1;
    send(32'h4433_2211, 3, 1'b1);
    chk("w3_in_ready", 32'(in_ready), 32'd0);
    beat("w3_b1", 16'h2211, 2, 1'b0);
    tick();
    beat("w3_b2", 16'h0033, 1, 1'b1);
    tick();
    chk("w3_end_valid", 32'(out_valid), 32'd0);
    chk("w3_end_ready", 32'(in_ready), 32'd1);

    // Backpressure hold
    ready_4_output = 1'b0;
    send(32'hDDCC_BBAA, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat("bp_hold", 16'hBBAA, 2, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    ready_4_output = 1'b1;
    beat("bp_b1", 16'hBBAA, 2, 1'b0);
    tick();
    beat("bp_b2", 16'hDDCC, 2, 1'b1);
    tick();
    chk("bp_end_valid", 32'(out_valid), 32'd0);

    // Zero-count last word: single empty last beat
    send(32'h1234_5678, 0, 1'b1);
    beat("z_last", 16'h0000, 0, 1'b1);
    tick();
    chk("z_last_end", 32'(out_valid), 32'd0);
    chk("z_last_rdy", 32'(in_ready), 32'd1);

    // Zero-count non-last word: swallowed
    send(32'h1234_5678, 0, 1'b0);
    chk("z_nl_valid", 32'(out_valid), 32'd0);
    chk("z_nl_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("z_nl_valid2", 32'(out_valid), 32'd0);

    // Clamp of oversized count
    send(32'h0403_0201, 7, 1'b0);
    beat("cl_b1", 16'h0201, 2, 1'b0);
    tick();
    beat("cl_b2", 16'h0403, 2, 1'b0);
    tick();
    chk("cl_end", 32'(out_valid), 32'd0);

    // Asynchronous reset between beats
    send(32'h8877_6655, 4, 1'b1);
    beat("ar_b1", 16'h6655, 2, 1'b0);
    ready_4_output = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data",  32'(out_data),  32'd0);
    chk("ar_num",   out_num,        32'd0);
    tick();
    rst = 1'b0;
    ready_4_output = 1'b1;
    tick();
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_no_rest", 32'(out_valid), 32'd0);
    tick();
    chk("ar_no_rest2", 32'(out_valid), 32'd0);

    // Back-to-back words, second held while first drains
    in_valid = 1'b1;
    in_data  = 32'h0000_2211;
    in_num   = 32'd2;
    in_last  = 1'b0;
    tick();
    in_data  = 32'h0000_0033;
    in_num   = 32'd1;
    in_last  = 1'b1;
    chk("bb_in_ready", 32'(in_ready), 32'd0);
    beat("bb_w1", 16'h2211, 2, 1'b0);
    if (out_valid) blk_sum += int'(out_num);
    tick();
    chk("bb_bubble_valid", 32'(out_valid), 32'd0);
    chk("bb_bubble_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    beat("bb_w2", 16'h0033, 1, 1'b1);
    if (out_valid) blk_sum += int'(out_num);
    tick();
    chk("bb_end", 32'(out_valid), 32'd0);
    chk("bb_sum", 32'(blk_sum), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
